// File: rtl/vector_data_memory.sv
// Vector CPU data memory: R-lane combinational reads, R-lane stores in RUN, and a byte-serial host preload/dump port.
// Reads have zero latency. Stores are visible the next cycle. Dump bytes hold while out_ready is low.
module vector_data_memory #(
  parameter int I     = 32,
  parameter int N     = 8,
  parameter int R     = 6,
  parameter int DEPTH = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [I-1:0]        Address,
  input  logic                MemWrite,
  input  logic [R-1:0][N-1:0] WriteData,
  output logic [R-1:0][N-1:0] ReadData,
  input  logic                start,
  input  logic                EndFlag,
  input  logic                load_req,
  input  logic                in_valid,
  input  logic [N-1:0]        in_data,
  input  logic                in_last,
  output logic                in_ready,
  output logic                out_valid,
  output logic [N-1:0]        out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic [1:0]          mem_state,
  output logic                addr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LASTPTR = AW'(DEPTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DUMP = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] ptr;
  logic [N-1:0]  mem [DEPTH];

  logic [AW-1:0] base;
  logic          highBits;
  logic          loadFire;
  logic          cpuStore;

  assign base     = Address[AW-1:0];
  assign highBits = |Address[I-1:AW];
  assign loadFire = (state == LOAD) && in_valid;
  assign cpuStore = (state == RUN) && MemWrite;

  // Lane addresses wrap naturally in AW-bit arithmetic.
  always_comb begin
    for (int i = 0; i < R; i++) begin
      ReadData[i] = mem[base + AW'(i)];
    end
  end

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DUMP);
  assign out_data  = mem[ptr];
  assign out_last  = (state == DUMP) && (ptr == LASTPTR);
  assign mem_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_req) begin
            state    <= LOAD;
            ptr      <= '0;
            addr_err <= 1'b0;
          end else if (start) begin
            state <= RUN;
          end
        end
        LOAD: begin
          if (in_valid) begin
            ptr <= ptr + 1'b1;
            if (in_last || ptr == LASTPTR) state <= IDLE;
          end
        end
        RUN: begin
          if (MemWrite && highBits) addr_err <= 1'b1;
          if (EndFlag) begin
            state <= DUMP;
            ptr   <= '0;
          end
        end
        DUMP: begin
          if (out_ready) begin
            ptr <= ptr + 1'b1;
            if (ptr == LASTPTR) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Contents survive reset; reset only suppresses writes in its own cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (loadFire) begin
        mem[ptr] <= in_data;
      end else if (cpuStore) begin
        for (int i = 0; i < R; i++) begin
          mem[base + AW'(i)] <= WriteData[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_data_memory.sv
// Randomized bench for vector_data_memory against an array model of memory contents.
module tb_vector_data_memory;
  localparam int I = 32, N = 8, R = 6, DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic [I-1:0]        Address;
  logic                MemWrite;
  logic [R-1:0][N-1:0] WriteData;
  logic [R-1:0][N-1:0] ReadData;
  logic                start, EndFlag, load_req;
  logic                in_valid, in_last, in_ready;
  logic [N-1:0]        in_data;
  logic                out_valid, out_last, out_ready;
  logic [N-1:0]        out_data;
  logic [1:0]          mem_state;
  logic                addr_err;

  vector_data_memory #(.I(I), .N(N), .R(R), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .Address(Address), .MemWrite(MemWrite),
    .WriteData(WriteData), .ReadData(ReadData), .start(start), .EndFlag(EndFlag),
    .load_req(load_req), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .mem_state(mem_state), .addr_err(addr_err)
  );

  int nCompared = 0;
  int nMismatched = 0;
  logic [N-1:0] memModel [DEPTH];
  int k, cyc, a;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] expRead(input int addr);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < R; i++) v[i*N +: N] = memModel[(addr + i) % DEPTH];
    return v;
  endfunction

  task automatic checkRead(input string tag, input int addr);
    Address = I'(addr);
    #1;
    chk(tag, 64'(ReadData), expRead(addr % DEPTH));
  endtask

  // One CPU store in RUN; the model applies it with modular lane addressing.
  task automatic store(input logic [I-1:0] addr, input logic [R*N-1:0] d);
    Address = addr; WriteData = d; MemWrite = 1'b1;
    tick;
    MemWrite = 1'b0;
    for (int i = 0; i < R; i++) memModel[int'((addr % DEPTH + i) % DEPTH)] = d[i*N +: N];
  endtask

  function automatic logic [R*N-1:0] rndData();
    return {$urandom, $urandom};
  endfunction

  initial begin
    reset = 1'b0; Address = '0; MemWrite = 1'b0; WriteData = '0; start = 1'b0;
    EndFlag = 1'b0; load_req = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0;
    tick; tick;
    chk("rst_state", 64'(mem_state), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_last", 64'(out_last), 0);
    chk("rst_addr_err", 64'(addr_err), 0);
    reset = 1'b1;

    // load_req beats start; full image preload with idle gaps and ignored CPU stores
    load_req = 1'b1; start = 1'b1;
    tick;
    load_req = 1'b0; start = 1'b0;
    chk("ld_wins", 64'(mem_state), 1);
    chk("ld_in_ready", 64'(in_ready), 1);
    k = 0; cyc = 0;
    while (k < DEPTH && cyc < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = N'($urandom);
      MemWrite  = $urandom_range(0, 1) == 1;
      Address   = I'($urandom_range(0, DEPTH - 1));
      WriteData = rndData();
      if (in_valid && in_ready) begin
        memModel[k] = in_data;
        k++;
      end
      tick;
      cyc++;
    end
    in_valid = 1'b0; MemWrite = 1'b0;
    chk("ld_count", 64'(k), DEPTH);
    chk("ld_full_exit", 64'(mem_state), 0);

    // IDLE stores are ignored
    for (int j = 0; j < 4; j++) begin
      a = $urandom_range(0, DEPTH - 1);
      Address = I'(a); WriteData = rndData(); MemWrite = 1'b1;
      tick;
      checkRead("idle_store_ignored", a);
    end
    MemWrite = 1'b0;

    // short preload terminated by in_last
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    chk("pre_state_load", 64'(mem_state), 1);
    for (int j = 0; j < 6; j++) begin
      in_valid = 1'b1; in_data = N'(8'h10 + j); in_last = (j == 5);
      memModel[j] = in_data;
      tick;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("pre_state_idle", 64'(mem_state), 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("pre_state_run", 64'(mem_state), 2);
    Address = '0;
    #1;
    chk("pre_lanes", 64'(ReadData), 64'h0000_1514_1312_1110);

    // wrapping store at the top of memory
    store(I'(DEPTH - 2), 48'hA5A4_A3A2_A1A0);
    Address = I'(DEPTH - 2);
    #1;
    chk("wrap_lanes", 64'(ReadData), 64'h0000_A5A4_A3A2_A1A0);
    checkRead("wrap_low", 0);
    chk("wrap_no_err", 64'(addr_err), 0);

    // random stores, with ignored start pulses mixed in
    for (int j = 0; j < 40; j++) begin
      a = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 1) == 1) store(I'(a), rndData());
      else begin
        start = 1'b1;
        tick;
        start = 1'b0;
      end
      checkRead("run_rd_store", a);
      checkRead("run_rd_rand", $urandom_range(0, DEPTH - 1));
    end
    chk("run_state", 64'(mem_state), 2);
    chk("run_no_err", 64'(addr_err), 0);

    // out-of-range store wraps and sets sticky addr_err
    store(I'(DEPTH + 4), rndData());
    chk("oor_err", 64'(addr_err), 1);
    checkRead("oor_lanes", 4);
    store(I'(7), rndData());
    chk("oor_sticky", 64'(addr_err), 1);

    // store committed in the EndFlag cycle
    Address = I'(100); WriteData = rndData(); MemWrite = 1'b1; EndFlag = 1'b1;
    tick;
    for (int i = 0; i < R; i++) memModel[100 + i] = WriteData[i];
    MemWrite = 1'b0; EndFlag = 1'b0;
    chk("end_state_dump", 64'(mem_state), 3);
    chk("end_out_valid", 64'(out_valid), 1);
    chk("end_first_byte", 64'(out_data), 64'(memModel[0]));

    // abort a dump with reset at ptr 5
    out_ready = 1'b1;
    repeat (5) tick;
    out_ready = 1'b0;
    chk("abort_ptr5", 64'(out_data), 64'(memModel[5]));
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("abort_state", 64'(mem_state), 0);
    chk("abort_out_valid", 64'(out_valid), 0);
    chk("abort_err_clr", 64'(addr_err), 0);

    // second run raises addr_err again, then a full dump with stalls
    start = 1'b1;
    tick;
    start = 1'b0;
    store(I'(DEPTH * 3 + 1000), rndData());
    chk("run2_err", 64'(addr_err), 1);
    EndFlag = 1'b1;
    tick;
    EndFlag = 1'b0;
    chk("run2_dump", 64'(mem_state), 3);
    k = 0; cyc = 0;
    while (k < DEPTH && cyc < 10000) begin
      out_ready = (cyc < 3) ? (cyc != 1) : ($urandom_range(0, 2) != 0);
      chk("dump_vld", 64'(out_valid), 1);
      chk(out_ready ? "dump_dat" : "dump_hold", 64'(out_data), 64'(memModel[k]));
      chk("dump_last", 64'(out_last), 64'(k == DEPTH - 1));
      if (out_ready) k++;
      tick;
      cyc++;
    end
    out_ready = 1'b0;
    chk("dump_count", 64'(k), DEPTH);
    chk("dump_done_state", 64'(mem_state), 0);
    chk("dump_done_vld", 64'(out_valid), 0);

    // LOAD clears addr_err; single-byte preload
    load_req = 1'b1;
    tick;
    load_req = 1'b0;
    chk("ld2_err_clr", 64'(addr_err), 0);
    chk("ld2_state", 64'(mem_state), 1);
    in_valid = 1'b1; in_last = 1'b1; in_data = N'($urandom);
    memModel[0] = in_data;
    tick;
    in_valid = 1'b0; in_last = 1'b0;
    chk("ld2_idle", 64'(mem_state), 0);
    checkRead("ld2_read", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
